// File: rtl/cdb_arbiter.sv
// cdb_arbiter: two-source round-robin common data bus arbiter with per-source FIFOs.
// Ports: clk_in/rst_in (async active-low) clock and reset; rdy_in global enable;
// flush_in discards all queued results; alu_b_in/alu_result_in and
// lbuffer_b_in/lbuffer_result_in are result pushes (tag 0 = none) with
// alu_rdy_out/lbuffer_rdy_out acceptance; cdb_b_out/cdb_result_out/cdb_src_out
// form the registered broadcast (tag 0 = idle, src 0 = ALU, 1 = load buffer).
// Define CDB_BYPASS_EN to let an empty source's incoming result go straight to the bus.
module cdb_arbiter #(
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic [ROB_WIDTH-1:0]  alu_b_in,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    output logic                  alu_rdy_out,
    input  logic [ROB_WIDTH-1:0]  lbuffer_b_in,
    input  logic [DATA_WIDTH-1:0] lbuffer_result_in,
    output logic                  lbuffer_rdy_out,
    output logic [ROB_WIDTH-1:0]  cdb_b_out,
    output logic [DATA_WIDTH-1:0] cdb_result_out,
    output logic                  cdb_src_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [ROB_WIDTH-1:0]  tag_mem [2][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] res_mem [2][FIFO_DEPTH];
    logic [AW-1:0]         head [2];
    logic [AW-1:0]         tail [2];
    logic [CW-1:0]         count [2];
    logic                  last_grant;
    logic [ROB_WIDTH-1:0]  in_tag [2];
    logic [DATA_WIDTH-1:0] in_res [2];
    logic [1:0]            can_push, push, nonempty, cand, store, pop;
    logic                  grant_valid, grant_sel;
    logic [ROB_WIDTH-1:0]  grant_tag;
    logic [DATA_WIDTH-1:0] grant_res;
    assign alu_rdy_out     = can_push[0];
    assign lbuffer_rdy_out = can_push[1];
    always_comb begin
        in_tag[0] = alu_b_in;
        in_tag[1] = lbuffer_b_in;
        in_res[0] = alu_result_in;
        in_res[1] = lbuffer_result_in;
        for (int s = 0; s < 2; s++) begin
            can_push[s] = rst_in && rdy_in && !flush_in && (count[s] < CW'(FIFO_DEPTH));
            push[s]     = (in_tag[s] != '0) && can_push[s];
            nonempty[s] = count[s] != '0;
        end
`ifdef CDB_BYPASS_EN
        cand = nonempty | push;
`else
        cand = nonempty;
`endif
        grant_valid = |cand;
        grant_sel   = &cand ? ~last_grant : cand[1];
        // An empty granted source can only be a bypass candidate: take the live input.
        grant_tag = nonempty[grant_sel] ? tag_mem[grant_sel][head[grant_sel]] : in_tag[grant_sel];
        grant_res = nonempty[grant_sel] ? res_mem[grant_sel][head[grant_sel]] : in_res[grant_sel];
        for (int s = 0; s < 2; s++) begin
            pop[s]   = grant_valid && (grant_sel == 1'(s)) && nonempty[s];
            store[s] = push[s] && !(grant_valid && (grant_sel == 1'(s)) && !nonempty[s]);
        end
    end
    always_ff @(posedge clk_in) begin
        for (int s = 0; s < 2; s++) begin
            if (store[s]) begin
                tag_mem[s][tail[s]] <= in_tag[s];
                res_mem[s][tail[s]] <= in_res[s];
            end
        end
    end
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int s = 0; s < 2; s++) begin
                head[s]  <= '0;
                tail[s]  <= '0;
                count[s] <= '0;
            end
            last_grant     <= 1'b1;
            cdb_b_out      <= '0;
            cdb_result_out <= '0;
            cdb_src_out    <= 1'b0;
        end else if (!rdy_in) begin
            cdb_b_out <= '0;
        end else if (flush_in) begin
            for (int s = 0; s < 2; s++) begin
                head[s]  <= '0;
                tail[s]  <= '0;
                count[s] <= '0;
            end
            cdb_b_out <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (store[s]) tail[s] <= tail[s] + AW'(1);
                if (pop[s]) head[s] <= head[s] + AW'(1);
                count[s] <= count[s] + CW'(store[s]) - CW'(pop[s]);
            end
            cdb_b_out <= grant_valid ? grant_tag : '0;
            if (grant_valid) begin
                cdb_result_out <= grant_res;
                cdb_src_out    <= grant_sel;
            end
            if (&cand) last_grant <= grant_sel;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter.
module tb_cdb_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        flush_in = 1'b0;
    logic [3:0]  alu_b_in = '0;
    logic [31:0] alu_result_in = '0;
    logic        alu_rdy_out;
    logic [3:0]  lbuffer_b_in = '0;
    logic [31:0] lbuffer_result_in = '0;
    logic        lbuffer_rdy_out;
    logic [3:0]  cdb_b_out;
    logic [31:0] cdb_result_out;
    logic        cdb_src_out;
    int errors = 0;
    int checks = 0;
    logic [3:0] cont_exp [10] = '{0, 1, 9, 2, 10, 3, 11, 4, 12, 0};
    logic [3:0] full_exp [15] = '{0, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 0};
    cdb_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .alu_b_in(alu_b_in), .alu_result_in(alu_result_in), .alu_rdy_out(alu_rdy_out),
        .lbuffer_b_in(lbuffer_b_in), .lbuffer_result_in(lbuffer_result_in),
        .lbuffer_rdy_out(lbuffer_rdy_out), .cdb_b_out(cdb_b_out),
        .cdb_result_out(cdb_result_out), .cdb_src_out(cdb_src_out)
    );
    always #5 clk_in = ~clk_in;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic chk_cdb(input string tag, input logic [3:0] exp);
        check({tag, " tag"}, 32'(cdb_b_out), 32'(exp));
        if (exp != 0) begin
            check({tag, " result"}, cdb_result_out, exp >= 9 ? 32'hB000_0000 | 32'(exp) : 32'hA000_0000 | 32'(exp));
            check({tag, " src"}, 32'(cdb_src_out), 32'(exp >= 9));
        end
    endtask
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask
    task automatic drive(input logic [3:0] a, input logic [3:0] l);
        alu_b_in = a;
        alu_result_in = 32'hA000_0000 | 32'(a);
        lbuffer_b_in = l;
        lbuffer_result_in = 32'hB000_0000 | 32'(l);
    endtask
    task automatic do_reset();
        drive(0, 0);
        rdy_in = 1'b1;
        flush_in = 1'b0;
        rst_in = 1'b0;
        repeat (2) tick();
        rst_in = 1'b1;
    endtask
    initial begin
        // reset: async assertion, pushes ignored, outputs cleared
        drive(3, 0);
        #1 rst_in = 1'b0;
        #1;
        check("rst cdb_b", 32'(cdb_b_out), 0);
        check("rst result", cdb_result_out, 0);
        check("rst src", 32'(cdb_src_out), 0);
        check("rst alu_rdy", 32'(alu_rdy_out), 0);
        check("rst lb_rdy", 32'(lbuffer_rdy_out), 0);
        repeat (2) tick();
        check("rst hold cdb_b", 32'(cdb_b_out), 0);
        rst_in = 1'b1;
        drive(0, 0);
        #1;
        check("post-rst alu_rdy", 32'(alu_rdy_out), 1);
        check("post-rst lb_rdy", 32'(lbuffer_rdy_out), 1);
        tick();
        chk_cdb("post-rst idle", 0);
        // single ALU result
        drive(5, 0);
        alu_result_in = 32'hDEAD_BEEF;
        tick();
        drive(0, 0);
`ifdef CDB_BYPASS_EN
        check("single e1 tag", 32'(cdb_b_out), 5);
        check("single e1 result", cdb_result_out, 32'hDEAD_BEEF);
        tick();
        check("single e2 tag", 32'(cdb_b_out), 0);
`else
        check("single e1 tag", 32'(cdb_b_out), 0);
        tick();
        check("single e2 tag", 32'(cdb_b_out), 5);
        check("single e2 result", cdb_result_out, 32'hDEAD_BEEF);
        check("single e2 src", 32'(cdb_src_out), 0);
        tick();
        check("single e3 tag", 32'(cdb_b_out), 0);
`endif
        // contention: strict alternation starting with ALU
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(i < 4 ? 4'(i + 1) : 4'd0, i < 4 ? 4'(i + 9) : 4'd0);
            tick();
            chk_cdb($sformatf("cont e%0d", i + 1), cont_exp[i]);
        end
        // full: ALU FIFO fills under contention, a push while not ready is dropped
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(i < 8 ? 4'(i + 1) : 4'd0, i < 6 ? 4'(i + 9) : 4'd0);
            #1;
            if (i < 8) begin
                check($sformatf("full alu_rdy e%0d", i + 1), 32'(alu_rdy_out), 32'(i < 7));
                check($sformatf("full lb_rdy e%0d", i + 1), 32'(lbuffer_rdy_out), 32'(i != 6));
            end
            tick();
            chk_cdb($sformatf("full e%0d", i + 1), full_exp[i]);
        end
        // flush discards queued entries and the push presented during the flush
        do_reset();
        drive(1, 9);
        tick();
        chk_cdb("flush e1", 0);
        drive(2, 10);
        tick();
        chk_cdb("flush e2", 1);
        drive(3, 0);
        tick();
        chk_cdb("flush e3", 9);
        drive(4, 0);
        flush_in = 1'b1;
        #1;
        check("flush alu_rdy", 32'(alu_rdy_out), 0);
        tick();
        flush_in = 1'b0;
        drive(0, 0);
        chk_cdb("flush e4", 0);
        tick();
        chk_cdb("flush e5", 0);
        tick();
        chk_cdb("flush e6", 0);
        drive(7, 0);
        tick();
        drive(0, 0);
        chk_cdb("flush e7", 0);
        tick();
        chk_cdb("flush e8", 7);
        tick();
        chk_cdb("flush e9", 0);
        // stall freezes queues and silences the bus
        do_reset();
        drive(1, 9);
        tick();
        drive(2, 0);
        tick();
        chk_cdb("stall e2", 1);
        drive(0, 0);
        rdy_in = 1'b0;
        #1;
        check("stall alu_rdy", 32'(alu_rdy_out), 0);
        check("stall lb_rdy", 32'(lbuffer_rdy_out), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cdb($sformatf("stall s%0d", i + 1), 0);
        end
        rdy_in = 1'b1;
        tick();
        chk_cdb("stall r1", 9);
        tick();
        chk_cdb("stall r2", 2);
        tick();
        chk_cdb("stall r3", 0);
        // reset mid-operation drops queued results
        do_reset();
        drive(1, 9);
        tick();
        drive(0, 0);
        tick();
        chk_cdb("midrst e2", 1);
        rst_in = 1'b0;
        #1;
        check("midrst async cdb_b", 32'(cdb_b_out), 0);
        tick();
        rst_in = 1'b1;
        tick();
        chk_cdb("midrst after1", 0);
        tick();
        chk_cdb("midrst after2", 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
